// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the two-port register-file arbiter.
// The FSM encoding and parameter defaults live here so the top and bench agree.
package regfile_arb_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_GRANT = 2'd2
   } state_t;

   localparam int AW_DEF         = 2;
   localparam int DW_DEF         = 4;
   localparam int INIT_VALUE_DEF = 0;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// whichever requester was not granted last (last: 0 = A, 1 = B).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto one external register file, clearing every
// location after reset. All outputs come straight from registers.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int              AW         = AW_DEF,
   parameter int              DW         = DW_DEF,
   parameter logic [DW-1:0]   INIT_VALUE = DW'(INIT_VALUE_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [2*AW-1:0]   addr,
   input  logic [2*DW-1:0]   wdata,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DW-1:0]     rdata,
   output logic              rf_we,
   output logic [AW-1:0]     rf_addr,
   output logic [DW-1:0]     rf_wdata,
   input  logic [DW-1:0]     rf_rdata,
   output logic              busy
);

   state_t          state_reg, state_next;
   logic            last_reg, last_next;
   logic [1:0]      gnt_reg, gnt_next;
   logic [1:0]      rvalid_reg, rvalid_next;
   logic [DW-1:0]   rdata_reg, rdata_next;
   logic            rf_we_reg, rf_we_next;
   logic [AW-1:0]   rf_addr_reg, rf_addr_next;
   logic [DW-1:0]   rf_wdata_reg, rf_wdata_next;
   logic            busy_reg, busy_next;

   logic [1:0]      arb_grant;
   logic            arb_idx;
   logic [AW-1:0]   req_addr  [2];
   logic [DW-1:0]   req_wdata [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_req_slice
      assign req_addr[gi]  = addr[gi*AW +: AW];
      assign req_wdata[gi] = wdata[gi*DW +: DW];
   end

   rr_arb2 u_arb (
      .req   (req),
      .last  (last_reg),
      .grant (arb_grant)
   );

   assign arb_idx = arb_grant[1];

   always_comb begin
      state_next    = state_reg;
      last_next     = last_reg;
      gnt_next      = 2'b00;
      rvalid_next   = 2'b00;
      rdata_next    = rdata_reg;
      rf_we_next    = rf_we_reg;
      rf_addr_next  = rf_addr_reg;
      rf_wdata_next = rf_wdata_reg;
      busy_next     = busy_reg;

      case (state_reg)
         ST_INIT: begin
            // rf_we low here means this is the first edge out of reset
            if (!rf_we_reg) begin
               rf_we_next    = 1'b1;
               rf_addr_next  = '0;
               rf_wdata_next = INIT_VALUE;
            end else if (rf_addr_reg == {AW{1'b1}}) begin
               rf_we_next = 1'b0;
               busy_next  = 1'b0;
               state_next = ST_IDLE;
            end else begin
               rf_addr_next = rf_addr_reg + 1'b1;
            end
         end
         ST_IDLE: begin
            rf_we_next = 1'b0;
            if (|req) begin
               gnt_next      = arb_grant;
               rf_we_next    = we[arb_idx];
               rf_addr_next  = req_addr[arb_idx];
               rf_wdata_next = req_wdata[arb_idx];
               last_next     = arb_idx;
               state_next    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            rf_we_next = 1'b0;
            state_next = ST_IDLE;
            if (!rf_we_reg) begin
               rdata_next  = rf_rdata;
               rvalid_next = gnt_reg;
            end
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_INIT;
         last_reg     <= 1'b1;
         gnt_reg      <= 2'b00;
         rvalid_reg   <= 2'b00;
         rdata_reg    <= '0;
         rf_we_reg    <= 1'b0;
         rf_addr_reg  <= '0;
         rf_wdata_reg <= '0;
         busy_reg     <= 1'b1;
      end else begin
         state_reg    <= state_next;
         last_reg     <= last_next;
         gnt_reg      <= gnt_next;
         rvalid_reg   <= rvalid_next;
         rdata_reg    <= rdata_next;
         rf_we_reg    <= rf_we_next;
         rf_addr_reg  <= rf_addr_next;
         rf_wdata_reg <= rf_wdata_next;
         busy_reg     <= busy_next;
      end
   end

   assign gnt      = gnt_reg;
   assign rvalid   = rvalid_reg;
   assign rdata    = rdata_reg;
   assign rf_we    = rf_we_reg;
   assign rf_addr  = rf_addr_reg;
   assign rf_wdata = rf_wdata_reg;
   assign busy     = busy_reg;

endmodule
